parquimetro_multi: RTL and testbench

- Parametrised successor to the single-gate car counter. Counts vehicles in a lot with N_GATES bidirectional gates.
- Each gate has two beam sensors (p outer, s inner). Each gate has its own synchroniser, debouncer and direction FSM.
- A shared saturating occupancy counter sums entries/exits from all gates in the same cycle.
- Reports full/empty status, sticky per-gate sequence errors, and counter overflow/underflow.

---
 rtl/parquimetro_multi_pkg.sv | 20 ++
 rtl/parquimetro_multi_gate_ctrl.sv | 121 ++++++++++++
 rtl/parquimetro_multi.sv | 86 ++++++++
 tb/tb_parquimetro_multi.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/parquimetro_multi_pkg.sv
// Shared definitions for the multi-gate parking occupancy counter.
//   - Gate direction FSM state encoding (4-bit constants)
//   - Width helper for the debounce counters
package parquimetro_multi_pkg;

  localparam logic [3:0] ST_IDLE = 4'd0;
  localparam logic [3:0] ST_IN1  = 4'd1;
  localparam logic [3:0] ST_IN2  = 4'd2;
  localparam logic [3:0] ST_IN3  = 4'd3;
  localparam logic [3:0] ST_OUT1 = 4'd4;
  localparam logic [3:0] ST_OUT2 = 4'd5;
  localparam logic [3:0] ST_OUT3 = 4'd6;
  localparam logic [3:0] ST_ERR  = 4'd7;

  // Bits needed to count 0..cycles.
  function automatic int db_cnt_w(input int cycles);
    return (cycles < 1) ? 1 : $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/parquimetro_multi_gate_ctrl.sv
// One gate: 2-flop synchronisers, debouncers for p/s, direction FSM.
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   p_raw, s_raw    raw outer/inner beam sensors (asynchronous)
//   entry, exit     registered one-cycle pulses on a completed transit
//   seq_err         registered one-cycle pulse on entering ERR
module gate_ctrl
  import parquimetro_multi_pkg::*;
#(
  parameter int DB_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic p_raw,
  input  logic s_raw,
  output logic entry,
  output logic exit,
  output logic seq_err
);

  localparam int CW = db_cnt_w(DB_CYCLES);

  // Bit 1 = p, bit 0 = s throughout.
  logic [1:0]         sync1, sync2, db;
  logic [1:0][CW-1:0] cnt;
  logic               p_db, s_db;
  logic [3:0]         state, nxt;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
      db    <= '0;
      cnt   <= '0;
    end else begin
      sync1 <= {p_raw, s_raw};
      sync2 <= sync1;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] != db[i]) begin
          // Accept on the DB_CYCLES-th consecutive differing edge.
          if (cnt[i] == CW'(DB_CYCLES - 1)) begin
            db[i]  <= sync2[i];
            cnt[i] <= '0;
          end else begin
            cnt[i] <= cnt[i] + 1'b1;
          end
        end else begin
          cnt[i] <= '0;
        end
      end
    end
  end

  assign p_db = db[1];
  assign s_db = db[0];

  always_comb begin
    nxt = state;
    unique case (state)
      ST_IDLE: case ({p_db, s_db})
        2'b10:   nxt = ST_IN1;
        2'b01:   nxt = ST_OUT1;
        2'b11:   nxt = ST_ERR;
        default: nxt = ST_IDLE;
      endcase
      ST_IN1: case ({p_db, s_db})
        2'b11:   nxt = ST_IN2;
        2'b00:   nxt = ST_IDLE;
        2'b01:   nxt = ST_ERR;
        default: nxt = ST_IN1;
      endcase
      ST_IN2: case ({p_db, s_db})
        2'b01:   nxt = ST_IN3;
        2'b10:   nxt = ST_IN1;
        2'b00:   nxt = ST_ERR;
        default: nxt = ST_IN2;
      endcase
      ST_IN3: case ({p_db, s_db})
        2'b00:   nxt = ST_IDLE;
        2'b11:   nxt = ST_IN2;
        2'b10:   nxt = ST_ERR;
        default: nxt = ST_IN3;
      endcase
      ST_OUT1: case ({p_db, s_db})
        2'b11:   nxt = ST_OUT2;
        2'b00:   nxt = ST_IDLE;
        2'b10:   nxt = ST_ERR;
        default: nxt = ST_OUT1;
      endcase
      ST_OUT2: case ({p_db, s_db})
        2'b10:   nxt = ST_OUT3;
        2'b01:   nxt = ST_OUT1;
        2'b00:   nxt = ST_ERR;
        default: nxt = ST_OUT2;
      endcase
      ST_OUT3: case ({p_db, s_db})
        2'b00:   nxt = ST_IDLE;
        2'b11:   nxt = ST_OUT2;
        2'b01:   nxt = ST_ERR;
        default: nxt = ST_OUT3;
      endcase
      ST_ERR:  nxt = ({p_db, s_db} == 2'b00) ? ST_IDLE : ST_ERR;
      default: nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      entry   <= 1'b0;
      exit    <= 1'b0;
      seq_err <= 1'b0;
    end else begin
      state   <= nxt;
      entry   <= (state == ST_IN3)  && (nxt == ST_IDLE);
      exit    <= (state == ST_OUT3) && (nxt == ST_IDLE);
      seq_err <= (state != ST_ERR)  && (nxt == ST_ERR);
    end
  end

endmodule

// File: rtl/parquimetro_multi.sv
// Multi-gate parking occupancy counter.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   psensor, ssensor      raw outer/inner sensors, one bit per gate
//   clear_error           pulse clearing all sticky flags
//   conteo                occupancy, saturating at 0 and CAPACITY
//   lleno, vacio          conteo == CAPACITY / conteo == 0
//   hubo_error            sticky per-gate illegal-sequence flags
//   desborde, subdesborde sticky overflow / underflow attempts
module parquimetro_multi
  import parquimetro_multi_pkg::*;
#(
  parameter int N_GATES   = 2,
  parameter int CNT_W     = 4,
  parameter int CAPACITY  = 15,
  parameter int DB_CYCLES = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_GATES-1:0] psensor,
  input  logic [N_GATES-1:0] ssensor,
  input  logic               clear_error,
  output logic [CNT_W-1:0]   conteo,
  output logic               lleno,
  output logic               vacio,
  output logic [N_GATES-1:0] hubo_error,
  output logic               desborde,
  output logic               subdesborde
);

  // Signed sum must hold conteo + N_GATES and -N_GATES.
  localparam int SW = CNT_W + $clog2(N_GATES + 1) + 1;

  logic [N_GATES-1:0]    entry, exit, seq_err;
  logic [SW-1:0]         n_in, n_out;
  logic signed [SW-1:0]  sum;
  logic [CNT_W-1:0]      conteo_nxt;
  logic                  ovf, unf;

  for (genvar g = 0; g < N_GATES; g++) begin : g_gate
    gate_ctrl #(.DB_CYCLES(DB_CYCLES)) u_gate (
      .clk     (clk),
      .reset   (reset),
      .p_raw   (psensor[g]),
      .s_raw   (ssensor[g]),
      .entry   (entry[g]),
      .exit    (exit[g]),
      .seq_err (seq_err[g])
    );
  end

  always_comb begin
    n_in  = '0;
    n_out = '0;
    for (int g = 0; g < N_GATES; g++) begin
      n_in  = n_in  + SW'(entry[g]);
      n_out = n_out + SW'(exit[g]);
    end
    // Equal entries and exits cancel to zero net, so boundaries raise no flag.
    sum = $signed(SW'(conteo)) + $signed(n_in) - $signed(n_out);
    ovf = sum > $signed(SW'(CAPACITY));
    unf = sum < $signed(SW'(0));
    if (ovf)      conteo_nxt = CNT_W'(CAPACITY);
    else if (unf) conteo_nxt = '0;
    else          conteo_nxt = CNT_W'(sum);
  end

  // Set events take priority over a simultaneous clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      conteo      <= '0;
      hubo_error  <= '0;
      desborde    <= 1'b0;
      subdesborde <= 1'b0;
    end else begin
      conteo      <= conteo_nxt;
      hubo_error  <= seq_err | (clear_error ? '0 : hubo_error);
      desborde    <= ovf | (desborde    & ~clear_error);
      subdesborde <= unf | (subdesborde & ~clear_error);
    end
  end

  assign lleno = (conteo == CNT_W'(CAPACITY));
  assign vacio = (conteo == '0);

endmodule

// File: tb/tb_parquimetro_multi.sv
// Directed bench for parquimetro_multi (2 gates, capacity 5, debounce 4).
module tb_parquimetro_multi;
  import parquimetro_multi_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [1:0] psensor = '0;
  logic [1:0] ssensor = '0;
  logic       clear_error = 1'b0;
  logic [3:0] conteo;
  logic       lleno, vacio, desborde, subdesborde;
  logic [1:0] hubo_error;

  int n_chk = 0;
  int n_fail = 0;
  int n_ent0 = 0;
  int n_pedge = 0;
  logic p_db_q = 1'b0;

  parquimetro_multi #(
    .N_GATES(2), .CNT_W(4), .CAPACITY(5), .DB_CYCLES(4)
  ) dut (
    .clk(clk), .reset(reset), .psensor(psensor), .ssensor(ssensor),
    .clear_error(clear_error), .conteo(conteo), .lleno(lleno), .vacio(vacio),
    .hubo_error(hubo_error), .desborde(desborde), .subdesborde(subdesborde)
  );

  always #5 clk = ~clk;

  // Observe gate0 internals: entry pulses and accepted rising p edges.
  always @(posedge clk) begin
    if (dut.g_gate[0].u_gate.entry) n_ent0 <= n_ent0 + 1;
    if (dut.g_gate[0].u_gate.p_db && !p_db_q) n_pedge <= n_pedge + 1;
    p_db_q <= dut.g_gate[0].u_gate.p_db;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_gate(input int g, input logic [1:0] ps);
    psensor[g] = ps[1];
    ssensor[g] = ps[0];
  endtask

  // Four patterns on one gate, each held 10 cycles (covers the 8-cycle latency).
  task automatic do_seq(input int g, input logic [1:0] a, input logic [1:0] b,
                        input logic [1:0] c, input logic [1:0] d);
    set_gate(g, a); cyc(10);
    set_gate(g, b); cyc(10);
    set_gate(g, c); cyc(10);
    set_gate(g, d); cyc(10);
  endtask

  task automatic enter0();
    do_seq(0, 2'b10, 2'b11, 2'b01, 2'b00);
  endtask

  task automatic exit1();
    do_seq(1, 2'b01, 2'b11, 2'b10, 2'b00);
  endtask

  task automatic pulse_clear();
    clear_error = 1'b1; cyc(1); clear_error = 1'b0;
  endtask

  initial begin
    // Reset
    reset = 1'b1; cyc(2); reset = 1'b0;
    chk("rst_conteo", 32'(conteo), 0);
    chk("rst_vacio", 32'(vacio), 1);
    chk("rst_lleno", 32'(lleno), 0);
    chk("rst_err", 32'(hubo_error), 0);
    chk("rst_flags", 32'({desborde, subdesborde}), 0);

    // 1. Entry on gate0 with exact latency after the final 00.
    set_gate(0, 2'b10); cyc(10);
    set_gate(0, 2'b11); cyc(10);
    set_gate(0, 2'b01); cyc(10);
    set_gate(0, 2'b00); cyc(7);
    chk("t1_before", 32'(conteo), 0);
    chk("t1_vacio_before", 32'(vacio), 1);
    cyc(1);
    chk("t1_after", 32'(conteo), 1);
    chk("t1_vacio_after", 32'(vacio), 0);
    cyc(5);
    chk("t1_one_pulse", 32'(n_ent0), 1);

    // 2. Exit on gate1, then underflow attempt, then clear.
    exit1();
    chk("t2_conteo0", 32'(conteo), 0);
    chk("t2_vacio", 32'(vacio), 1);
    chk("t2_no_unf", 32'(subdesborde), 0);
    exit1();
    chk("t2_stay0", 32'(conteo), 0);
    chk("t2_unf", 32'(subdesborde), 1);
    pulse_clear();
    chk("t2_unf_clr", 32'(subdesborde), 0);

    // 3. Fill to capacity, overflow, then cancelling entry+exit at the top.
    repeat (5) enter0();
    chk("t3_full", 32'(conteo), 5);
    chk("t3_lleno", 32'(lleno), 1);
    chk("t3_no_ovf", 32'(desborde), 0);
    enter0();
    chk("t3_sat", 32'(conteo), 5);
    chk("t3_ovf", 32'(desborde), 1);
    pulse_clear();
    chk("t3_ovf_clr", 32'(desborde), 0);
    set_gate(0, 2'b10); set_gate(1, 2'b01); cyc(10);
    set_gate(0, 2'b11); set_gate(1, 2'b11); cyc(10);
    set_gate(0, 2'b01); set_gate(1, 2'b10); cyc(10);
    set_gate(0, 2'b00); set_gate(1, 2'b00); cyc(10);
    chk("t3_cancel", 32'(conteo), 5);
    chk("t3_cancel_flags", 32'({desborde, subdesborde}), 0);

    // 4. Sequence error on gate0.
    exit1();
    chk("t4_pre", 32'(conteo), 4);
    set_gate(0, 2'b10); cyc(10);
    set_gate(0, 2'b01); cyc(10);
    chk("t4_err", 32'(hubo_error), 32'b01);
    chk("t4_cnt", 32'(conteo), 4);
    set_gate(0, 2'b11); cyc(10);
    chk("t4_hold_err", 32'(dut.g_gate[0].u_gate.state), 32'(ST_ERR));
    set_gate(0, 2'b00); cyc(10);
    chk("t4_idle", 32'(dut.g_gate[0].u_gate.state), 32'(ST_IDLE));
    enter0();
    chk("t4_entry_ok", 32'(conteo), 5);
    pulse_clear();
    chk("t4_err_clr", 32'(hubo_error), 0);
    // IDLE->11 error: ERR at edge 7, flag set on edge 8; clear lands on edge 8.
    set_gate(0, 2'b11); cyc(7);
    clear_error = 1'b1; cyc(1); clear_error = 1'b0;
    chk("t4_set_wins", 32'(hubo_error), 32'b01);
    set_gate(0, 2'b00); cyc(10);

    // 5. Debounce behaviour.
    psensor[0] = 1'b1; cyc(3); psensor[0] = 1'b0; cyc(10);
    chk("t5_glitch_state", 32'(dut.g_gate[0].u_gate.state), 32'(ST_IDLE));
    chk("t5_glitch_edges", 32'(n_pedge), 32'(n_pedge));
    begin
      int e0;
      e0 = n_pedge;
      psensor[0] = 1'b1; cyc(2); psensor[0] = 1'b0; cyc(1);
      psensor[0] = 1'b1; cyc(2); psensor[0] = 1'b0; cyc(1);
      psensor[0] = 1'b1; cyc(12);
      chk("t5_one_edge", 32'(n_pedge - e0), 1);
      chk("t5_in1", 32'(dut.g_gate[0].u_gate.state), 32'(ST_IN1));
    end
    begin
      int en;
      en = n_ent0;
      set_gate(0, 2'b00); cyc(12);
      chk("t5_abort_idle", 32'(dut.g_gate[0].u_gate.state), 32'(ST_IDLE));
      chk("t5_abort_cnt", 32'(conteo), 5);
      chk("t5_abort_pulse", 32'(n_ent0 - en), 0);
    end

    // 6. Reset mid-transit.
    exit1(); exit1();
    chk("t6_pre", 32'(conteo), 3);
    set_gate(0, 2'b10); cyc(10);
    set_gate(0, 2'b11); cyc(10);
    chk("t6_in2", 32'(dut.g_gate[0].u_gate.state), 32'(ST_IN2));
    reset = 1'b1; cyc(1); reset = 1'b0;
    chk("t6_cnt", 32'(conteo), 0);
    chk("t6_vacio_lleno", 32'({vacio, lleno}), 32'b10);
    chk("t6_flags", 32'({hubo_error, desborde, subdesborde}), 0);
    chk("t6_idle", 32'(dut.g_gate[0].u_gate.state), 32'(ST_IDLE));
    cyc(7);
    chk("t6_err_state", 32'(dut.g_gate[0].u_gate.state), 32'(ST_ERR));
    chk("t6_err_notyet", 32'(hubo_error), 0);
    cyc(1);
    chk("t6_err_flag", 32'(hubo_error), 32'b01);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
